// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler: cycle-timed phase sequencer for a highway /
// country-road intersection with a latched pedestrian crossing request.
// Yellow, all-red and walk intervals are counted in clock cycles. Lights are
// registered and decoded from the next state, so they change with the state.
// Optional build macro: EMERGENCY_PREEMPT_EN adds the level input emg.
module intersection_phase_scheduler #(
  parameter int unsigned TW       = 8,
  parameter int unsigned MIN_HG   = 8,
  parameter int unsigned MAX_CG   = 10,
  parameter int unsigned Y_CYC    = 3,
  parameter int unsigned AR_CYC   = 2,
  parameter int unsigned WALK_CYC = 6
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       car_x,
  input  logic       ped_req,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic       emg,
`endif
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_HG  = 3'd0,
    S_HY  = 3'd1,
    S_AR  = 3'd2,
    S_CG  = 3'd3,
    S_CY  = 3'd4,
    S_PED = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    O_HG  = 2'd0,
    O_HY  = 2'd1,
    O_CY  = 2'd2,
    O_PED = 2'd3
  } origin_t;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  // Last timer value of each timed interval (interval of N cycles ends at N-1)
  localparam logic [TW-1:0] HG_LAST   = TW'(MIN_HG - 1);
  localparam logic [TW-1:0] CG_LAST   = TW'(MAX_CG - 1);
  localparam logic [TW-1:0] Y_LAST    = TW'(Y_CYC - 1);
  localparam logic [TW-1:0] AR_LAST   = TW'(AR_CYC - 1);
  localparam logic [TW-1:0] WALK_LAST = TW'(WALK_CYC - 1);

  state_t          state, state_nx;
  origin_t         origin, origin_nx;
  logic [TW-1:0]   timer;
  logic            ped_pend;
  logic            emg_act;
  logic            enter_ped;

`ifdef EMERGENCY_PREEMPT_EN
  assign emg_act = emg;
`else
  assign emg_act = 1'b0;
`endif

  assign enter_ped = (state_nx == S_PED) && (state != S_PED);
  assign phase     = state;

  // Next-state and clearance-origin selection
  always_comb begin
    state_nx  = state;
    origin_nx = origin;
    case (state)
      S_HG: begin
        if ((timer >= HG_LAST) && (car_x || ped_pend) && !emg_act)
          state_nx = S_HY;
      end
      S_HY: begin
        if (timer == Y_LAST) begin
          state_nx  = S_AR;
          origin_nx = O_HY;
        end
      end
      S_AR: begin
        if (timer == AR_LAST) begin
          if (emg_act)
            state_nx = S_HG;
          else begin
            case (origin)
              O_HY:    state_nx = ped_pend ? S_PED : (car_x ? S_CG : S_HG);
              O_CY:    state_nx = ped_pend ? S_PED : S_HG;
              default: state_nx = S_HG;
            endcase
          end
        end
      end
      S_CG: begin
        if (!car_x || (timer == CG_LAST) || emg_act)
          state_nx = S_CY;
      end
      S_CY: begin
        if (timer == Y_LAST) begin
          state_nx  = S_AR;
          origin_nx = O_CY;
        end
      end
      S_PED: begin
        if (timer == WALK_LAST) begin
          state_nx  = S_AR;
          origin_nx = O_PED;
        end
      end
      default: begin
        // Illegal codes recover through a full clearance back to highway green
        state_nx  = S_AR;
        origin_nx = O_PED;
      end
    endcase
  end

  // State, origin and phase timer registers
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state  <= S_HG;
      origin <= O_HG;
      timer  <= '0;
    end else begin
      state  <= state_nx;
      origin <= origin_nx;
      if (state_nx != state)
        timer <= '0;
      else if (timer != '1)
        timer <= timer + 1'b1;
    end
  end

  // Pedestrian request latch; clearing on PED entry wins over a new request
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)
      ped_pend <= 1'b0;
    else if (enter_ped)
      ped_pend <= 1'b0;
    else if (ped_req)
      ped_pend <= 1'b1;
  end

  // Registered light outputs decoded from the next state
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      hwy     <= GREEN;
      cntry   <= RED;
      walk    <= 1'b0;
      ped_ack <= 1'b0;
    end else begin
      ped_ack <= enter_ped;
      walk    <= (state_nx == S_PED);
      case (state_nx)
        S_HG:    begin hwy <= GREEN;  cntry <= RED;    end
        S_HY:    begin hwy <= YELLOW; cntry <= RED;    end
        S_CG:    begin hwy <= RED;    cntry <= GREEN;  end
        S_CY:    begin hwy <= RED;    cntry <= YELLOW; end
        default: begin hwy <= RED;    cntry <= RED;    end
      endcase
    end
  end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Self-checking bench for intersection_phase_scheduler: directed scenarios
// plus randomized car/pedestrian traffic against a phase-duration model.
module tb_intersection_phase_scheduler;

  localparam int MIN_HG = 8, MAX_CG = 10, Y_CYC = 3, AR_CYC = 2, WALK_CYC = 6;
  localparam int P_HG = 0, P_HY = 1, P_AR = 2, P_CG = 3, P_CY = 4, P_PED = 5;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       car_x = 1'b0;
  logic       ped_req = 1'b0;
  logic [1:0] hwy, cntry;
  logic       walk, ped_ack;
  logic [2:0] phase;
  logic [8:0] dut_vec;

  int n_checks = 0;
  int n_fail   = 0;

  intersection_phase_scheduler #(
    .TW(8), .MIN_HG(MIN_HG), .MAX_CG(MAX_CG), .Y_CYC(Y_CYC),
    .AR_CYC(AR_CYC), .WALK_CYC(WALK_CYC)
  ) dut (
    .clock(clock), .clear(clear), .car_x(car_x), .ped_req(ped_req),
    .hwy(hwy), .cntry(cntry), .walk(walk), .ped_ack(ped_ack), .phase(phase)
  );

  assign dut_vec = {phase, hwy, cntry, walk, ped_ack};

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  // Tracks the displayed phase and how many cycles it has been shown so far.
  int m_phase, m_elapsed, m_from;
  bit m_pend, m_ack;
  int hwy_of[6]   = '{2, 1, 0, 0, 0, 0};
  int cntry_of[6] = '{0, 0, 0, 2, 1, 0};

  function automatic int dur_of(int p);
    case (p)
      P_HY, P_CY: return Y_CYC;
      P_AR:       return AR_CYC;
      P_PED:      return WALK_CYC;
      default:    return 0;
    endcase
  endfunction

  function void model_reset();
    m_phase = P_HG; m_elapsed = 1; m_from = P_HG; m_pend = 0; m_ack = 0;
  endfunction

  function void model_edge(bit c, bit p);
    int nxt;
    nxt = m_phase;
    if (m_phase == P_HG) begin
      if (m_elapsed >= MIN_HG && (c || m_pend)) nxt = P_HY;
    end else if (m_phase == P_CG) begin
      if (!c || m_elapsed == MAX_CG) nxt = P_CY;
    end else if (m_elapsed == dur_of(m_phase)) begin
      if (m_phase == P_AR) begin
        if (m_from == P_HY)      nxt = m_pend ? P_PED : (c ? P_CG : P_HG);
        else if (m_from == P_CY) nxt = m_pend ? P_PED : P_HG;
        else                     nxt = P_HG;
      end else begin
        m_from = m_phase;
        nxt = P_AR;
      end
    end
    m_ack = (nxt == P_PED) && (m_phase != P_PED);
    if (m_ack)  m_pend = 0;
    else if (p) m_pend = 1;
    m_elapsed = (nxt == m_phase) ? m_elapsed + 1 : 1;
    m_phase = nxt;
  endfunction

  function automatic logic [8:0] exp_vec();
    return {3'(m_phase), 2'(hwy_of[m_phase]), 2'(cntry_of[m_phase]),
            (m_phase == P_PED), m_ack};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit c, input bit p);
    car_x = c; ped_req = p;
    @(posedge clock);
    model_edge(c, p);
    #1;
  endtask

  task automatic do_reset();
    clear = 1'b0; car_x = 1'b0; ped_req = 1'b0;
    @(posedge clock); #1;
    clear = 1'b1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear = 1'b0; car_x = 1'b1; ped_req = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (dut_vec !== 9'b000_10_00_0_0) begin
      n_fail++;
      $display("FAIL reset_hold: got %b required %b", dut_vec, 9'b000_10_00_0_0);
    end
    clear = 1'b1; car_x = 1'b0; ped_req = 1'b0;
    model_reset();
    n_checks++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_release: got %b required %b", dut_vec, exp_vec());
    end
  endtask

  // Country held: HG 0-7, HY 8-10, AR 11-12, CG 13-22, CY 23-25, AR 26-27, HG 28
  function automatic int plan_car(int cyc);
    if (cyc < 8)  return P_HG;
    if (cyc < 11) return P_HY;
    if (cyc < 13) return P_AR;
    if (cyc < 23) return P_CG;
    if (cyc < 26) return P_CY;
    if (cyc < 28) return P_AR;
    return P_HG;
  endfunction

  task automatic test_car_held();
    do_reset();
    for (int k = 0; k < 32; k++) begin
      drive(1'b1, 1'b0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL car_held_model c%0d: got %b required %b", k + 1, dut_vec, exp_vec());
      end
      if (k + 1 < 30) begin
        n_checks++;
        if (int'(phase) != plan_car(k + 1)) begin
          n_fail++;
          $display("FAIL car_held_plan c%0d: got phase %0d required %0d", k + 1, phase, plan_car(k + 1));
        end
      end
    end
  endtask

  task automatic test_country_short();
    int want;
    do_reset();
    for (int k = 0; k < 24; k++) begin
      drive(k <= 14, 1'b0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL cshort_model c%0d: got %b required %b", k + 1, dut_vec, exp_vec());
      end
      want = -1;
      if (k + 1 >= 13 && k + 1 <= 15) want = P_CG;
      if (k + 1 >= 16 && k + 1 <= 18) want = P_CY;
      if (k + 1 == 19 || k + 1 == 20) want = P_AR;
      if (k + 1 == 21) want = P_HG;
      if (want >= 0) begin
        n_checks++;
        if (int'(phase) != want) begin
          n_fail++;
          $display("FAIL cshort_plan c%0d: got phase %0d required %0d", k + 1, phase, want);
        end
      end
    end
  endtask

  task automatic test_ped_pulse();
    logic [8:0] want;
    do_reset();
    for (int k = 0; k < 24; k++) begin
      drive(1'b0, k == 2);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL ped_model c%0d: got %b required %b", k + 1, dut_vec, exp_vec());
      end
      want = 9'b000_10_00_0_0;
      if (k + 1 >= 8 && k + 1 <= 10)  want = 9'b001_01_00_0_0;
      if (k + 1 >= 11 && k + 1 <= 12) want = 9'b010_00_00_0_0;
      if (k + 1 >= 13 && k + 1 <= 18) want = {3'b101, 2'b00, 2'b00, 1'b1, (k + 1 == 13)};
      if (k + 1 >= 19 && k + 1 <= 20) want = 9'b010_00_00_0_0;
      n_checks++;
      if (dut_vec !== want) begin
        n_fail++;
        $display("FAIL ped_plan c%0d: got %b required %b", k + 1, dut_vec, want);
      end
    end
  endtask

  task automatic test_ped_and_car();
    do_reset();
    for (int k = 0; k < 40; k++) begin
      drive(1'b1, k == 3);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL pedcar_model c%0d: got %b required %b", k + 1, dut_vec, exp_vec());
      end
      if (k + 1 == 13 || k + 1 == 21 || k + 1 == 34) begin
        n_checks++;
        if (int'(phase) != ((k + 1 == 13) ? P_PED : (k + 1 == 21) ? P_HG : P_CG)) begin
          n_fail++;
          $display("FAIL pedcar_order c%0d: got phase %0d", k + 1, phase);
        end
      end
    end
  endtask

  task automatic test_back_to_back_ped();
    int acks = 0;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      drive(1'b0, k <= 14);
      if (ped_ack === 1'b1 && k + 1 <= 28) acks++;
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL pedheld_model c%0d: got %b required %b", k + 1, dut_vec, exp_vec());
      end
      if (k + 1 == 29 || k + 1 == 34) begin
        n_checks++;
        if (int'(phase) != ((k + 1 == 29) ? P_HY : P_PED) || ped_ack !== (k + 1 == 34)) begin
          n_fail++;
          $display("FAIL pedheld_round c%0d: got phase %0d ack %b", k + 1, phase, ped_ack);
        end
      end
    end
    n_checks++;
    if (acks != 1) begin
      n_fail++;
      $display("FAIL pedheld_ack_count: got %0d required 1", acks);
    end
  endtask

  task automatic test_hg_saturate();
    do_reset();
    for (int k = 0; k < 259; k++) begin
      drive(k >= 257, 1'b0);
      if (k >= 250) begin
        n_checks++;
        if (dut_vec !== exp_vec()) begin
          n_fail++;
          $display("FAIL hg_sat c%0d: got %b required %b", k + 1, dut_vec, exp_vec());
        end
      end
    end
  endtask

  task automatic test_reset_mid_cy();
    do_reset();
    repeat (24) drive(1'b1, 1'b0);
    n_checks++;
    if (int'(phase) != P_CY) begin
      n_fail++;
      $display("FAIL midcy_reach: got phase %0d required %0d", phase, P_CY);
    end
    #2 clear = 1'b0;
    #1;
    n_checks++;
    if (dut_vec !== 9'b000_10_00_0_0) begin
      n_fail++;
      $display("FAIL midcy_async: got %b required %b", dut_vec, 9'b000_10_00_0_0);
    end
    @(posedge clock); #1;
    clear = 1'b1;
    model_reset();
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 1'b0);
      n_checks++;
      if (dut_vec !== exp_vec() || (k + 1 == 8 && int'(phase) != P_HY)) begin
        n_fail++;
        $display("FAIL midcy_restart c%0d: got %b required %b", k + 1, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    bit c = 0;
    bit p;
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 9) == 0) c = ~c;
      p = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 299) == 0) begin
        clear = 1'b0;
        #1;
        n_checks++;
        if (dut_vec !== 9'b000_10_00_0_0) begin
          n_fail++;
          $display("FAIL rand_reset k%0d: got %b", k, dut_vec);
        end
        @(posedge clock); #1;
        clear = 1'b1;
        model_reset();
      end
      drive(c, p);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL rand k%0d: got %b required %b", k, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_car_held();
    test_country_short();
    test_ped_pulse();
    test_ped_and_car();
    test_back_to_back_ped();
    test_hg_saturate();
    test_reset_mid_cy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
